// File: rtl/ehgu_pll_pkg.sv
// Shared types and helpers for the fractional-N PLL lock detector.
package ehgu_pll_pkg;

  // Default divider geometry; the lock detector parameters default to these.
  localparam int PLL_INT_WIDTH  = 3;
  localparam int PLL_FRAC_WIDTH = 4;
  localparam int PLL_WIN_LOG2   = 4;
  localparam int PLL_CW         = PLL_INT_WIDTH + PLL_WIN_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    EVAL    = 2'd3
  } lock_state_e;

  // Expected VCO cycles per window for the default geometry. The shift is
  // exact because the window spans at least 2^FRAC_WIDTH reference periods.
  function automatic logic [PLL_CW-1:0] exp_count(
    input logic [PLL_INT_WIDTH-1:0]  int_v,
    input logic [PLL_FRAC_WIDTH-1:0] frac_v
  );
    logic [PLL_CW-1:0] ratio;
    ratio = PLL_CW'({int_v, frac_v});
    return ratio << (PLL_WIN_LOG2 - PLL_FRAC_WIDTH);
  endfunction

endpackage

// File: rtl/ehgu_sync_edge.sv
// Two-flop synchronizer followed by an edge register; emits a one-cycle
// pulse for each rising edge of an asynchronous input.
module ehgu_sync_edge (
  input  logic clkin,
  input  logic rstn,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  // Shift the sampled input through the synchronizer and the edge register.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Synchronizer and edge-register flops.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/ehgu_pll_lock_detect.sv
// PLL lock detector: counts VCO cycles over 2^WIN_LOG2 reference periods and
// compares the count with the programmed fractional divide ratio.
module ehgu_pll_lock_detect
  import ehgu_pll_pkg::*;
#(
  parameter  int INT_WIDTH  = PLL_INT_WIDTH,
  parameter  int FRAC_WIDTH = PLL_FRAC_WIDTH,
  parameter  int WIN_LOG2   = PLL_WIN_LOG2,
  parameter  int TOL        = 2,
  parameter  int LOCK_CNT   = 4,
  localparam int CW         = INT_WIDTH + WIN_LOG2 + 1
) (
  input  logic                  clkin,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  ref_in,
  input  logic [INT_WIDTH-1:0]  int_div,
  input  logic [FRAC_WIDTH-1:0] frac_div,
  output logic                  lock,
  output logic [CW-1:0]         meas_count,
  output logic                  meas_valid,
  output logic                  ovf
);

  localparam int DW   = INT_WIDTH + FRAC_WIDTH;
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int CWP1 = CW + 1;

  lock_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIN_LOG2-1:0]  edges_q, edges_d;
  logic [DW-1:0]        div_q, div_d;
  logic [GW-1:0]        good_q, good_d;
  logic                 lock_q, lock_d;
  logic [CW-1:0]        meas_count_q, meas_count_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 ovf_q, ovf_d;

  logic                 ref_rise;
  logic [DW-1:0]        div_in;
  logic                 div_change;
  logic                 cnt_sat;
  logic [CW-1:0]        cnt_inc;
  logic [CW-1:0]        exp_c;
  logic signed [CW:0]   diff_c;
  logic [CW:0]          abs_c;
  logic                 in_tol;

  ehgu_sync_edge u_ref_edge (
    .clkin    (clkin),
    .rstn     (rstn),
    .async_in (ref_in),
    .rise     (ref_rise)
  );

  assign div_in     = {int_div, frac_div};
  assign div_change = (div_in != div_q);
  assign cnt_sat    = &cnt_q;
  assign cnt_inc    = cnt_sat ? cnt_q : cnt_q + CW'(1);

  // Expected count for the latched ratio and its absolute error against the
  // last measurement, evaluated one bit wider so the difference cannot wrap.
  always_comb begin
    exp_c  = CW'({1'b0, div_q}) << (WIN_LOG2 - FRAC_WIDTH);
    diff_c = $signed({1'b0, meas_count_q}) - $signed({1'b0, exp_c});
    abs_c  = diff_c[CW] ? -diff_c : diff_c;
    in_tol = (abs_c <= CWP1'(TOL));
  end

  // Next-state, window counting and lock qualification.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    edges_d      = edges_q;
    div_d        = div_q;
    good_d       = good_q;
    lock_d       = lock_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    ovf_d        = ovf_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      edges_d = '0;
      good_d  = '0;
      lock_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end

        ARM: begin
          if (ref_rise) begin
            cnt_d   = '0;
            edges_d = '0;
            div_d   = div_in;
            state_d = MEASURE;
          end
        end

        MEASURE, EVAL: begin
          if (div_change) begin
            state_d = ARM;
            good_d  = '0;
            lock_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_sat) begin
              ovf_d = 1'b1;
            end
            if (ref_rise) begin
              edges_d = edges_q + WIN_LOG2'(1);
            end

            if (state_q == MEASURE) begin
              if (ref_rise && (&edges_q)) begin
                meas_count_d = cnt_inc;
                meas_valid_d = 1'b1;
                cnt_d        = '0;
                edges_d      = '0;
                div_d        = div_in;
                state_d      = EVAL;
              end
            end else begin
              state_d = MEASURE;
              if (in_tol && !ovf_q) begin
                if (good_q != GW'(LOCK_CNT)) begin
                  good_d = good_q + GW'(1);
                end
                if (good_q >= GW'(LOCK_CNT - 1)) begin
                  lock_d = 1'b1;
                end
              end else begin
                good_d = '0;
                lock_d = 1'b0;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      edges_q      <= '0;
      div_q        <= '0;
      good_q       <= '0;
      lock_q       <= 1'b0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edges_q      <= edges_d;
      div_q        <= div_d;
      good_q       <= good_d;
      lock_q       <= lock_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign lock       = lock_q;
  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign ovf        = ovf_q;

endmodule
